// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sequential logic unit: op codes, FSM states
// and a width helper used to size the popcount counters.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND      = 3'd0;
    localparam logic [2:0] OP_OR       = 3'd1;
    localparam logic [2:0] OP_XOR      = 3'd2;
    localparam logic [2:0] OP_NOT      = 3'd3;
    localparam logic [2:0] OP_NAND     = 3'd4;
    localparam logic [2:0] OP_NOR      = 3'd5;
    localparam logic [2:0] OP_XNOR     = 3'd6;
    localparam logic [2:0] OP_POPCOUNT = 3'd7;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    // Ceiling log2 that returns at least 1 so derived vectors are never zero-width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/popcount_serial.sv
// Bit-serial population counter: consumes one bit per cycle for WIDTH cycles
// after start, raising done in the last cycle with the final count presented.
module popcount_serial
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    localparam int CW = clog2(WIDTH + 1);

    logic             active_q, active_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [CW-1:0]    cnt_sum;
    logic             last_cycle;

    // done is combinational so the top can capture the final count on the
    // same edge that retires the last bit, giving exactly WIDTH busy cycles.
    always_comb begin
        cnt_sum    = cnt_q + CW'(shift_q[0]);
        last_cycle = (cyc_q == CW'(WIDTH - 1));
        done       = active_q && last_cycle;
        count      = WIDTH'(cnt_sum);

        active_d = active_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        cyc_d    = cyc_q;

        if (start) begin
            active_d = 1'b1;
            shift_d  = din;
            cnt_d    = '0;
            cyc_d    = '0;
        end else if (active_q) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_sum;
            cyc_d   = cyc_q + CW'(1);
            if (last_cycle) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            shift_q  <= '0;
            cnt_q    <= '0;
            cyc_q    <= '0;
        end else begin
            active_q <= active_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
        end
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Pipelined WIDTH-bit logic unit with valid/ready handshakes, an internal
// accumulator for chaining, and a multi-cycle serial popcount.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] logic_res;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             pc_start;
    logic             pc_done;
    logic [WIDTH-1:0] pc_count;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign operand_a = acc_en ? acc_q : x;
    assign pc_start  = accept && (op == OP_POPCOUNT);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign busy      = (state_q == COUNT);

    always_comb begin
        logic_res = '0;
        case (op)
            OP_AND:  logic_res = operand_a & y;
            OP_OR:   logic_res = operand_a | y;
            OP_XOR:  logic_res = operand_a ^ y;
            OP_NOT:  logic_res = ~operand_a;
            OP_NAND: logic_res = ~(operand_a & y);
            OP_NOR:  logic_res = ~(operand_a | y);
            OP_XNOR: logic_res = ~(operand_a ^ y);
            default: logic_res = '0;
        endcase
    end

    popcount_serial #(
        .WIDTH(WIDTH)
    ) u_popcount (
        .clk  (clk),
        .reset(reset),
        .start(pc_start),
        .din  (operand_a),
        .done (pc_done),
        .count(pc_count)
    );

    // A new result overrides the consume-clear, so out_valid stays high
    // across a simultaneous handshake and throughput is one per cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        result_d    = result_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        load_val    = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_POPCOUNT) begin
                        state_d = COUNT;
                    end else begin
                        load     = 1'b1;
                        load_val = logic_res;
                    end
                end
            end
            COUNT: begin
                if (pc_done) begin
                    load     = 1'b1;
                    load_val = pc_count;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (load) begin
            result_d    = load_val;
            zero_d      = (load_val == '0);
            parity_d    = ^load_val;
            acc_d       = load_val;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard testbench for logic_unit_seq: directed scenarios plus a random
// phase, with a behavioural model predicting every delivered result.
module tb_logic_unit_seq;

   localparam int W = 8;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    op;
   logic          acc_en;
   logic [W-1:0]  x;
   logic [W-1:0]  y;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          parity;
   logic          busy;

   int            compared;
   int            mismatched;
   logic [W-1:0]  expQ[$];
   logic [W-1:0]  accModel;

   logic_unit_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .acc_en   (acc_en),
      .x        (x),
      .y        (y),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .zero     (zero),
      .parity   (parity),
      .busy     (busy)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: what the operation means, not how the RTL builds it.
   function automatic logic [W-1:0] refModel(input logic [2:0] opI, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] r;
      case (opI)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = ~a;
         3'd4: r = ~(a & b);
         3'd5: r = ~(a | b);
         3'd6: r = ~(a ^ b);
         default: r = W'($countones(a));
      endcase
      return r;
   endfunction

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared = compared + 1;
      if (actual !== expected) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Presents one bundle and waits (bounded) for the handshake; the expected
   // result is pushed to the scoreboard on the cycle the DUT accepts it.
   task automatic applyStimulus(input logic [2:0] opI, input logic accI, input logic [W-1:0] xI,
                                input logic [W-1:0] yI, input bit randReady, output int waits);
      bit           accepted;
      logic [W-1:0] e;
      accepted = 0;
      waits    = 0;
      in_valid = 1'b1;
      op       = opI;
      acc_en   = accI;
      x        = xI;
      y        = yI;
      for (int c = 0; c < 100 && !accepted; c++) begin
         @(negedge clk);
         if (in_ready) begin
            e = refModel(opI, accI ? accModel : xI, yI);
            expQ.push_back(e);
            accModel = e;
            accepted = 1;
         end else begin
            waits = waits + 1;
         end
         @(posedge clk);
         #1;
         if (randReady) out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0;
      op       = 3'($urandom);
      x        = W'($urandom);
      y        = W'($urandom);
      if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   // Holds reset for the given number of edges; pending results are lost.
   task automatic doReset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      reset = 1'b0;
      expQ.delete();
      accModel = '0;
   endtask

   // Monitor: pops and compares whenever a transfer will occur at the next edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_output", {24'd0, result}, 32'hFFFF_FFFF);
         end else begin
            logic [W-1:0] e;
            e = expQ.pop_front();
            checkOutput("result", {24'd0, result}, {24'd0, e});
            checkOutput("zero", {31'd0, zero}, {31'd0, (e == '0)});
            checkOutput("parity", {31'd0, parity}, {31'd0, ^e});
         end
      end
   end

   initial begin
      int           waits;
      int           busyCycles;
      logic [W-1:0] bpExp;
      compared   = 0;
      mismatched = 0;
      accModel   = '0;
      in_valid   = 1'b0;
      op         = 3'd0;
      acc_en     = 1'b0;
      x          = '0;
      y          = '0;
      out_ready  = 1'b1;
      reset      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset values
      @(negedge clk);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_result", {24'd0, result}, 32'd0);
      checkOutput("rst_zero", {31'd0, zero}, 32'd1);
      checkOutput("rst_parity", {31'd0, parity}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Mid-stream reset with a result pending, then AND 0xF0 & 0x3C
      out_ready = 1'b0;
      applyStimulus(3'd1, 1'b0, 8'h12, 8'h34, 1'b0, waits);
      doReset(2);
      @(negedge clk);
      checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(3'd0, 1'b0, 8'hF0, 8'h3C, 1'b0, waits);
      @(negedge clk);
      checkOutput("and_latency", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;

      // Back-to-back with out_ready held high
      applyStimulus(3'd1, 1'b0, 8'h0F, 8'hF0, 1'b0, waits);
      checkOutput("b2b_wait0", waits, 32'd0);
      applyStimulus(3'd2, 1'b0, 8'hAA, 8'hFF, 1'b0, waits);
      checkOutput("b2b_wait1", waits, 32'd0);
      applyStimulus(3'd3, 1'b0, 8'h81, 8'h00, 1'b0, waits);
      checkOutput("b2b_wait2", waits, 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: XNOR 0,0 held for 5 cycles, then exactly one transfer
      out_ready = 1'b0;
      bpExp = refModel(3'd6, 8'h00, 8'h00);
      applyStimulus(3'd6, 1'b0, 8'h00, 8'h00, 1'b0, waits);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_result", {24'd0, result}, {24'd0, bpExp});
         checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("bp_single_transfer", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;

      // POPCOUNT 0xB7: WIDTH busy cycles, in_ready low, intruding bundle ignored
      applyStimulus(3'd7, 1'b0, 8'hB7, 8'h00, 1'b0, waits);
      busyCycles = 0;
      for (int k = 0; k < W; k++) begin
         if (k == 2) begin
            in_valid = 1'b1;
            op       = 3'd0;
            acc_en   = 1'b0;
            x        = 8'hFF;
            y        = 8'hFF;
         end
         if (k == 5) in_valid = 1'b0;
         @(negedge clk);
         if (busy) busyCycles++;
         checkOutput("pc_in_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("pc_no_early_valid", {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      checkOutput("pc_busy_cycles", busyCycles, W);
      @(negedge clk);
      checkOutput("pc_busy_done", {31'd0, busy}, 32'd0);
      checkOutput("pc_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;

      // Accumulator chain: 0xFF&0x0F, acc^0x3C, popcount(acc)
      applyStimulus(3'd0, 1'b0, 8'hFF, 8'h0F, 1'b0, waits);
      applyStimulus(3'd2, 1'b1, 8'h00, 8'h3C, 1'b0, waits);
      applyStimulus(3'd7, 1'b1, 8'h00, 8'h00, 1'b0, waits);
      repeat (W + 2) @(posedge clk);
      #1;

      // Reset during COUNT aborts; acc must read back as zero
      applyStimulus(3'd7, 1'b0, 8'hFF, 8'h00, 1'b0, waits);
      repeat (2) @(posedge clk);
      #1;
      doReset(1);
      @(negedge clk);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(3'd5, 1'b1, 8'h5A, 8'h00, 1'b0, waits);
      repeat (2) @(posedge clk);
      #1;

      // Random phase with random downstream backpressure
      for (int n = 0; n < 80; n++) begin
         applyStimulus(3'($urandom_range(0, 7)), 1'($urandom), W'($urandom), W'($urandom),
                       1'b1, waits);
      end

      // Drain everything still in flight
      out_ready = 1'b1;
      for (int c = 0; c < 200 && expQ.size() != 0; c++) begin
         @(posedge clk);
      end
      #1;
      checkOutput("drain_empty", expQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
